boid_pixel_writer: RTL and testbench

BOID_PIXEL_WRITER -- requirements
Module: boid_pixel_writer

---
 rtl/boid_pixel_writer_if.sv | 31 +++
 rtl/boid_pixel_writer.sv | 173 +++++++++++++++++
 tb/tb_boid_pixel_writer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/boid_pixel_writer_if.sv
// Command handshake bundle for boid_pixel_writer.
// master: issuer drives command fields and cmd_valid; slave: writer returns cmd_ready.
interface boid_pixel_writer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic [8:0] cmd_x;
    logic [7:0] cmd_y;
    logic [1:0] cmd_size;
    logic [7:0] cmd_color;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_x,
        output cmd_y,
        output cmd_size,
        output cmd_color,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_x,
        input  cmd_y,
        input  cmd_size,
        input  cmd_color,
        output cmd_ready
    );
endinterface

// File: rtl/boid_pixel_writer.sv
// Boid sprite / clear-screen pixel writer into an 8-bit on-chip SRAM framebuffer.
// Ports: clk, reset (sync, active high); cmd (slave handshake: op, x, y, size, color);
// busy; sram_address/clken/chipselect/write/writedata; pixel_count (debug).
// Optional: define BOID_PIXEL_CLIP_EN to suppress writes outside WIDTH x HEIGHT.
module boid_pixel_writer #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic                clk,
    input  logic                reset,
    boid_pixel_writer_if.slave  cmd,
    output logic                busy,
    output logic [16:0]         sram_address,
    output logic                sram_clken,
    output logic                sram_chipselect,
    output logic                sram_write,
    output logic [7:0]          sram_writedata,
    output logic [31:0]         pixel_count
);

    localparam logic [16:0] W17  = 17'(WIDTH);
    localparam logic [16:0] LAST = 17'(WIDTH * HEIGHT - 1);
`ifdef BOID_PIXEL_CLIP_EN
    localparam logic [16:0] H17  = 17'(HEIGHT);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t      state;
    logic [8:0]  x_q;
    logic [1:0]  sz_q;
    logic [1:0]  dx;
    logic [1:0]  dy;
    logic [16:0] row_base;
`ifdef BOID_PIXEL_CLIP_EN
    logic [7:0]  y_q;
`endif

    // y*WIDTH as a shift-add over the bits of y; WIDTH is constant,
    // so this reduces to a small adder tree.
    function automatic logic [16:0] row_base_of(input logic [7:0] y);
        logic [16:0] acc;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) acc = acc + (W17 << i);
        end
        return acc;
    endfunction

    logic [16:0] acc_base;
    logic [16:0] acc_addr;
    logic        acc_ok;
    logic        last_col;
    logic        last_px;
    logic [1:0]  nxt_dx;
    logic [1:0]  nxt_dy;
    logic [16:0] nxt_base;
    logic [16:0] nxt_addr;
    logic        nxt_ok;

    always_comb begin
        acc_base = row_base_of(cmd.cmd_y);
        acc_addr = acc_base + {8'b0, cmd.cmd_x};
        last_col = (dx == sz_q);
        last_px  = last_col && (dy == sz_q);
        nxt_dx   = last_col ? 2'd0 : dx + 2'd1;
        nxt_dy   = last_col ? dy + 2'd1 : dy;
        // Next row starts one framebuffer line further on.
        nxt_base = last_col ? row_base + W17 : row_base;
        nxt_addr = nxt_base + {8'b0, x_q} + {15'b0, nxt_dx};
`ifdef BOID_PIXEL_CLIP_EN
        acc_ok = ({8'b0, cmd.cmd_x} < W17)
              && ({9'b0, cmd.cmd_y} < H17);
        nxt_ok = ({7'b0, {1'b0, x_q} + {8'b0, nxt_dx}} < W17)
              && ({8'b0, {1'b0, y_q} + {7'b0, nxt_dy}} < H17);
`else
        acc_ok = 1'b1;
        nxt_ok = 1'b1;
`endif
    end

    assign busy = ~cmd.cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cmd.cmd_ready   <= 1'b1;
            x_q             <= '0;
            sz_q            <= '0;
            dx              <= '0;
            dy              <= '0;
            row_base        <= '0;
            sram_address    <= '0;
            sram_clken      <= 1'b0;
            sram_chipselect <= 1'b0;
            sram_write      <= 1'b0;
            sram_writedata  <= '0;
            pixel_count     <= '0;
`ifdef BOID_PIXEL_CLIP_EN
            y_q             <= '0;
`endif
        end else begin
            sram_clken  <= 1'b1;
            // Counts the write presented during the cycle now ending.
            pixel_count <= pixel_count + {31'b0, sram_write};
            unique case (state)
                IDLE: begin
                    sram_write      <= 1'b0;
                    sram_chipselect <= 1'b0;
                    if (cmd.cmd_valid) begin
                        cmd.cmd_ready  <= 1'b0;
                        x_q            <= cmd.cmd_x;
                        sz_q           <= cmd.cmd_size;
                        dx             <= '0;
                        dy             <= '0;
                        sram_writedata <= cmd.cmd_color;
`ifdef BOID_PIXEL_CLIP_EN
                        y_q            <= cmd.cmd_y;
`endif
                        if (cmd.cmd_op) begin
                            state           <= CLEAR;
                            sram_address    <= '0;
                            sram_write      <= 1'b1;
                            sram_chipselect <= 1'b1;
                        end else begin
                            state           <= DRAW;
                            row_base        <= acc_base;
                            sram_address    <= acc_addr;
                            sram_write      <= acc_ok;
                            sram_chipselect <= acc_ok;
                        end
                    end
                end
                DRAW: begin
                    if (last_px) begin
                        state           <= IDLE;
                        cmd.cmd_ready   <= 1'b1;
                        sram_write      <= 1'b0;
                        sram_chipselect <= 1'b0;
                    end else begin
                        dx              <= nxt_dx;
                        dy              <= nxt_dy;
                        row_base        <= nxt_base;
                        sram_address    <= nxt_addr;
                        sram_write      <= nxt_ok;
                        sram_chipselect <= nxt_ok;
                    end
                end
                CLEAR: begin
                    if (sram_address == LAST) begin
                        state           <= IDLE;
                        cmd.cmd_ready   <= 1'b1;
                        sram_write      <= 1'b0;
                        sram_chipselect <= 1'b0;
                    end else begin
                        sram_address    <= sram_address + 17'd1;
                    end
                end
                default: begin
                    state           <= IDLE;
                    cmd.cmd_ready   <= 1'b1;
                    sram_write      <= 1'b0;
                    sram_chipselect <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boid_pixel_writer.sv
// Directed testbench for boid_pixel_writer (320x240 framebuffer).
// Checks reset state, sprite draws, clip/no-clip edge draw, clear, and abort.
module tb_boid_pixel_writer;

    logic        clk;
    logic        reset;
    logic        busy;
    logic [16:0] sram_address;
    logic        sram_clken;
    logic        sram_chipselect;
    logic        sram_write;
    logic [7:0]  sram_writedata;
    logic [31:0] pixel_count;

    int vectors;
    int miscompares;

    boid_pixel_writer_if bus ();

    boid_pixel_writer #(
        .WIDTH  (320),
        .HEIGHT (240)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd             (bus),
        .busy            (busy),
        .sram_address    (sram_address),
        .sram_clken      (sram_clken),
        .sram_chipselect (sram_chipselect),
        .sram_write      (sram_write),
        .sram_writedata  (sram_writedata),
        .pixel_count     (pixel_count)
    );

    always #5 clk = ~clk;

    // Write log and busy-cycle count, sampled mid-cycle.
    logic [16:0] wr_addr[$];
    logic [7:0]  wr_data[$];
    int          busy_cyc;

    always @(negedge clk) begin
        if (sram_write) begin
            wr_addr.push_back(sram_address);
            wr_data.push_back(sram_writedata);
        end
        if (busy) busy_cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic issue(input bit op, input int x, input int y,
                         input int sz, input int color);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_x     = 9'(x);
        bus.cmd_y     = 8'(y);
        bus.cmd_size  = 2'(sz);
        bus.cmd_color = 8'(color);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_ready(input int lim);
        int n;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < lim) begin
            tick();
            n++;
        end
        chk("ready_timeout", 32'(bus.cmd_ready), 32'd1);
    endtask

    int base;
    int bc;
    int bad;
    int nz;

    initial begin
        clk           = 1'b0;
        reset         = 1'b1;
        vectors       = 0;
        miscompares   = 0;
        busy_cyc      = 0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_size  = '0;
        bus.cmd_color = '0;

        // Reset state
        tick();
        tick();
        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", pixel_count, 32'd0);
        chk("rst_write", 32'(sram_write), 32'd0);
        chk("rst_cs", 32'(sram_chipselect), 32'd0);
        chk("rst_clken", 32'(sram_clken), 32'd0);
        chk("rst_addr", 32'(sram_address), 32'd0);
        chk("rst_data", 32'(sram_writedata), 32'd0);
        reset = 1'b0;
        tick();
        chk("clken_on", 32'(sram_clken), 32'd1);
        chk("idle_ready", 32'(bus.cmd_ready), 32'd1);

        // Single pixel: 5*320+10 = 1610
        base = wr_addr.size();
        issue(1'b0, 10, 5, 0, 8'h3C);
        chk("px1_busy", 32'(busy), 32'd1);
        chk("px1_write", 32'(sram_write), 32'd1);
        chk("px1_cs", 32'(sram_chipselect), 32'd1);
        chk("px1_addr", 32'(sram_address), 32'd1610);
        chk("px1_data", 32'(sram_writedata), 32'h3C);
        tick();
        chk("px1_ready", 32'(bus.cmd_ready), 32'd1);
        chk("px1_wr_off", 32'(sram_write), 32'd0);
        chk("px1_count", pixel_count, 32'd1);
        chk("px1_nwr", 32'(wr_addr.size() - base), 32'd1);

        // 4x4 sprite at (100,20)
        do_reset();
        base = wr_addr.size();
        bc   = busy_cyc;
        issue(1'b0, 100, 20, 3, 8'hE0);
        wait_ready(100);
        chk("sq_nwr", 32'(wr_addr.size() - base), 32'd16);
        if (wr_addr.size() - base == 16) begin
            for (int dy = 0; dy < 4; dy++) begin
                for (int dx = 0; dx < 4; dx++) begin
                    chk("sq_addr", 32'(wr_addr[base + dy * 4 + dx]),
                        32'((20 + dy) * 320 + 100 + dx));
                end
            end
            chk("sq_data", 32'(wr_data[base + 15]), 32'hE0);
        end
        chk("sq_busy", 32'(busy_cyc - bc), 32'd16);
        chk("sq_count", pixel_count, 32'd16);

        // Bottom-right corner sprite at (318,238)
        do_reset();
        base = wr_addr.size();
        bc   = busy_cyc;
        issue(1'b0, 318, 238, 3, 8'h11);
        wait_ready(100);
        chk("edge_busy", 32'(busy_cyc - bc), 32'd16);
`ifdef BOID_PIXEL_CLIP_EN
        chk("edge_nwr", 32'(wr_addr.size() - base), 32'd4);
        if (wr_addr.size() - base == 4) begin
            chk("edge_a0", 32'(wr_addr[base]), 32'd76478);
            chk("edge_a1", 32'(wr_addr[base + 1]), 32'd76479);
            chk("edge_a2", 32'(wr_addr[base + 2]), 32'd76798);
            chk("edge_a3", 32'(wr_addr[base + 3]), 32'd76799);
        end
        chk("edge_count", pixel_count, 32'd4);
`else
        chk("edge_nwr", 32'(wr_addr.size() - base), 32'd16);
        if (wr_addr.size() - base == 16) begin
            chk("edge_first", 32'(wr_addr[base]), 32'd76478);
            chk("edge_last", 32'(wr_addr[base + 15]), 32'd77441);
        end
        chk("edge_count", pixel_count, 32'd16);
`endif

        // Clear screen, with an ignored command mid-way
        do_reset();
        base = wr_addr.size();
        bc   = busy_cyc;
        issue(1'b1, 0, 0, 0, 8'h00);
        chk("clr_busy0", 32'(busy), 32'd1);
        repeat (10) tick();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 1'b0;
        bus.cmd_x     = 9'd1;
        bus.cmd_y     = 8'd1;
        bus.cmd_size  = 2'd3;
        bus.cmd_color = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            chk("clr_noready", 32'(bus.cmd_ready), 32'd0);
            tick();
        end
        bus.cmd_valid = 1'b0;
        wait_ready(80000);
        chk("clr_nwr", 32'(wr_addr.size() - base), 32'd76800);
        bad = 0;
        nz  = 0;
        if (wr_addr.size() - base == 76800) begin
            for (int i = 0; i < 76800; i++) begin
                if (wr_addr[base + i] !== 17'(i)) bad++;
                if (wr_data[base + i] !== 8'h00) nz++;
            end
        end
        chk("clr_seq", 32'(bad), 32'd0);
        chk("clr_data", 32'(nz), 32'd0);
        chk("clr_busy", 32'(busy_cyc - bc), 32'd76800);
        chk("clr_count", pixel_count, 32'd76800);
        repeat (3) tick();
        chk("clr_noqueue", 32'(wr_addr.size() - base), 32'd76800);

        // Reset during the 8th write of a 4x4 draw at (0,0)
        do_reset();
        base = wr_addr.size();
        issue(1'b0, 0, 0, 3, 8'h55);
        repeat (7) tick();
        chk("abt_addr8", 32'(sram_address), 32'd323);
        chk("abt_wr8", 32'(sram_write), 32'd1);
        reset = 1'b1;
        tick();
        chk("abt_wr_off", 32'(sram_write), 32'd0);
        chk("abt_count", pixel_count, 32'd0);
        reset = 1'b0;
        tick();
        chk("abt_ready", 32'(bus.cmd_ready), 32'd1);
        repeat (4) tick();
        chk("abt_nwr", 32'(wr_addr.size() - base), 32'd8);
        chk("abt_count2", pixel_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
